// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: keypad events -> operand/operator entry,
// processor command issue over valid/ready, result/error display.
// Optional: define CALC_CHAIN_EN to let A/B in S_SHOW chain on the result.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   key_valid, key_value     held-key level and code from keypad scanner
//   op_valid/op_code/op_data command to processor, op_ready accept
//   res_valid/res_data/res_neg  result strobe from processor
//   disp_value, disp_err     nibble-coded FND word, error flag
//   busy                     command issue or result wait in progress
module calc_key_sequencer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key_valid,
  input  logic [3:0]  key_value,
  output logic        op_valid,
  output logic [2:0]  op_code,
  output logic [3:0]  op_data,
  input  logic        op_ready,
  input  logic        res_valid,
  input  logic [7:0]  res_data,
  input  logic        res_neg,
  output logic [15:0] disp_value,
  output logic        disp_err,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_A, S_OP, S_B, S_EQ, S_ISSUE, S_WAIT, S_SHOW, S_ERR
  } state_t;

  state_t        state, state_n;
  logic [3:0]    a_reg, a_n;
  logic [3:0]    b_reg, b_n;
  logic [1:0]    op_sel, op_sel_n;
  logic [7:0]    res_reg, res_n;
  logic [1:0]    cmd_idx, cmd_idx_n;
  logic [CW-1:0] tmo_cnt, tmo_n;
  logic          abort, abort_n;
  logic          key_valid_d;
  logic          op_valid_n;
  logic [2:0]    op_code_n;
  logic [3:0]    op_data_n;
  logic [15:0]   disp_n;

  logic       press, pr_dig, pr_op, pr_eq, pr_clr;
  logic [1:0] key_op;
  logic       abort_eff;
  logic [3:0] a_nib, op_nib, b_nib;

  // op_sel: 0 none, 1 add, 2 sub
  assign press  = key_valid & ~key_valid_d;
  assign pr_dig = press & (key_value <= 4'd9);
  assign pr_op  = press & ((key_value == 4'hA) | (key_value == 4'hB));
  assign pr_eq  = press & (key_value == 4'hE);
  assign pr_clr = press & (key_value == 4'hC);
  assign key_op = (key_value == 4'hA) ? 2'd1 : 2'd2;
  assign abort_eff = abort | pr_clr;

  assign busy     = (state == S_ISSUE) | (state == S_WAIT);
  assign disp_err = (state == S_ERR);

  always_comb begin
    state_n    = state;
    a_n        = a_reg;
    b_n        = b_reg;
    op_sel_n   = op_sel;
    res_n      = res_reg;
    cmd_idx_n  = cmd_idx;
    tmo_n      = tmo_cnt;
    abort_n    = abort;
    op_valid_n = op_valid;
    op_code_n  = op_code;
    op_data_n  = op_data;
    unique case (state)
      S_A: begin
        if (pr_dig) begin
          a_n     = key_value;
          state_n = S_OP;
        end
      end
      S_OP: begin
        if (pr_dig) begin
          a_n = key_value;
        end else if (pr_op) begin
          op_sel_n = key_op;
          state_n  = S_B;
        end
      end
      S_B: begin
        if (pr_dig) begin
          b_n     = key_value;
          state_n = S_EQ;
        end
      end
      S_EQ: begin
        if (pr_dig) begin
          b_n = key_value;
        end else if (pr_op) begin
          op_sel_n = key_op;
        end else if (pr_eq) begin
          cmd_idx_n = 2'd0;
          abort_n   = 1'b0;
          state_n   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (pr_clr) abort_n = 1'b1;
        if (!op_valid) begin
          op_valid_n = 1'b1;
          unique case (cmd_idx)
            2'd0: begin
              op_code_n = 3'd1;
              op_data_n = a_reg;
            end
            2'd1: begin
              op_code_n = 3'd2;
              op_data_n = b_reg;
            end
            default: begin
              op_code_n = (op_sel == 2'd2) ? 3'd4 : 3'd3;
              op_data_n = 4'd0;
            end
          endcase
        end else if (op_ready) begin
          // drop valid for one cycle between commands
          op_valid_n = 1'b0;
          op_code_n  = 3'd0;
          op_data_n  = 4'd0;
          if (cmd_idx == 2'd2) begin
            tmo_n   = '0;
            state_n = S_WAIT;
          end else begin
            cmd_idx_n = cmd_idx + 2'd1;
          end
        end
      end
      S_WAIT: begin
        if (pr_clr) abort_n = 1'b1;
        tmo_n = tmo_cnt + 1'b1;
        if (res_valid || tmo_n == TMO_MAX) begin
          abort_n = 1'b0;
          if (abort_eff) begin
            a_n      = 4'd0;
            b_n      = 4'd0;
            op_sel_n = 2'd0;
            state_n  = S_A;
          end else if (res_valid) begin
            res_n   = res_data;
            state_n = res_neg ? S_ERR : S_SHOW;
          end else begin
            state_n = S_ERR;
          end
        end
      end
      S_SHOW: begin
        if (pr_dig) begin
          a_n     = key_value;
          b_n     = 4'd0;
          state_n = S_OP;
        end
`ifdef CALC_CHAIN_EN
        else if (pr_op) begin
          if (res_reg <= 8'd15) begin
            a_n      = res_reg[3:0];
            b_n      = 4'd0;
            op_sel_n = key_op;
            state_n  = S_B;
          end else begin
            state_n = S_ERR;
          end
        end
`endif
      end
      S_ERR: begin
      end
    endcase
    if (pr_clr && !busy) begin
      a_n      = 4'd0;
      b_n      = 4'd0;
      op_sel_n = 2'd0;
      state_n  = S_A;
    end
  end

  // blank (F) for fields not yet entered
  always_comb begin
    a_nib  = (state == S_A) ? 4'hF : a_reg;
    b_nib  = (state == S_EQ || busy) ? b_reg : 4'hF;
    op_nib = 4'hF;
    if (op_sel == 2'd1) op_nib = 4'hA;
    if (op_sel == 2'd2) op_nib = 4'hB;
    disp_n = {a_nib, op_nib, b_nib, 4'hF};
    if (state == S_SHOW) disp_n = {8'hFF, res_reg};
    if (state == S_ERR)  disp_n = 16'hEEEE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_A;
      a_reg       <= 4'd0;
      b_reg       <= 4'd0;
      op_sel      <= 2'd0;
      res_reg     <= 8'd0;
      cmd_idx     <= 2'd0;
      tmo_cnt     <= '0;
      abort       <= 1'b0;
      key_valid_d <= 1'b0;
      op_valid    <= 1'b0;
      op_code     <= 3'd0;
      op_data     <= 4'd0;
      disp_value  <= 16'hFFFF;
    end else begin
      state       <= state_n;
      a_reg       <= a_n;
      b_reg       <= b_n;
      op_sel      <= op_sel_n;
      res_reg     <= res_n;
      cmd_idx     <= cmd_idx_n;
      tmo_cnt     <= tmo_n;
      abort       <= abort_n;
      key_valid_d <= key_valid;
      op_valid    <= op_valid_n;
      op_code     <= op_code_n;
      op_data     <= op_data_n;
      disp_value  <= disp_n;
    end
  end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Bench for calc_key_sequencer: random key stimulus, reference model,
// scoreboard queues for display words and processor commands.
module tb_calc_key_sequencer;

  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_value = 4'd0;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [3:0]  op_data;
  logic        op_ready = 1'b0;
  logic        res_valid = 1'b0;
  logic [7:0]  res_data = 8'd0;
  logic        res_neg = 1'b0;
  logic [15:0] disp_value;
  logic        disp_err;
  logic        busy;

  calc_key_sequencer #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .key_valid(key_valid), .key_value(key_value),
    .op_valid(op_valid), .op_code(op_code),
    .op_data(op_data), .op_ready(op_ready),
    .res_valid(res_valid), .res_data(res_data),
    .res_neg(res_neg), .disp_value(disp_value),
    .disp_err(disp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // scoreboards
  logic [15:0] dq[$];
  logic [6:0]  cq[$];

  // reference model: phase 0 A,1 OP,2 B,3 EQ,4 busy,5 SHOW,6 ERR
  int ph = 0, ma = 0, mb = 0, mop = 0, mres = 0;
  bit mabort = 0;
  logic [15:0] last_pred = 16'hFFFF;

  function automatic logic [15:0] mdisp();
    logic [3:0] an, on, bn;
    if (ph == 6) return 16'hEEEE;
    if (ph == 5) return {8'hFF, mres[7:0]};
    an = (ph == 0) ? 4'hF : 4'(ma);
    on = (mop == 0) ? 4'hF : (mop == 1) ? 4'hA : 4'hB;
    bn = (ph == 3 || ph == 4) ? 4'(mb) : 4'hF;
    return {an, on, bn, 4'hF};
  endfunction

  task automatic upd_disp();
    logic [15:0] d;
    d = mdisp();
    if (d != last_pred) begin
      dq.push_back(d);
      last_pred = d;
    end
  endtask

  task automatic model_key(int k);
    bit dig, opk;
    dig = (k <= 9);
    opk = (k == 10 || k == 11);
    if (k == 12 && ph == 4) mabort = 1;
    else if (k == 12) begin
      ma = 0; mb = 0; mop = 0; ph = 0;
    end else begin
      case (ph)
        0: if (dig) begin ma = k; ph = 1; end
        1: if (dig) ma = k;
           else if (opk) begin mop = k - 9; ph = 2; end
        2: if (dig) begin mb = k; ph = 3; end
        3: if (dig) mb = k;
           else if (opk) mop = k - 9;
           else if (k == 14) begin
             ph = 4;
             mabort = 0;
             cq.push_back({3'd1, 4'(ma)});
             cq.push_back({3'd2, 4'(mb)});
             cq.push_back({(mop == 1) ? 3'd3 : 3'd4, 4'd0});
           end
        5: if (dig) begin ma = k; mb = 0; ph = 1; end
`ifdef CALC_CHAIN_EN
           else if (opk) begin
             if (mres <= 15) begin
               ma = mres; mop = k - 9; mb = 0; ph = 2;
             end else ph = 6;
           end
`endif
        default: ;
      endcase
    end
    upd_disp();
  endtask

  task automatic model_end(bit got, int data, bit neg);
    if (mabort) begin
      ma = 0; mb = 0; mop = 0; ph = 0; mabort = 0;
    end else if (got) begin
      mres = data;
      ph = neg ? 6 : 5;
    end else ph = 6;
    upd_disp();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(int k, int hold = 1);
    key_valid = 1'b1;
    key_value = 4'(k);
    model_key(k);
    repeat (hold) tick();
    key_valid = 1'b0;
    repeat (1 + $urandom % 2) tick();
  endtask

  // mode 0: ready=1, 1: 20-cycle stall on LOAD_B, 2: random ready
  task automatic do_issue(int mode);
    int hs, budget, last, stall;
    bit h, busy_ok, gap_ok, stall_ok;
    hs = 0; budget = 300; last = -1; stall = 0;
    busy_ok = 1; gap_ok = 1; stall_ok = 1;
    while (hs < 3 && budget > 0) begin
      op_ready = 1'b1;
      if (mode == 2) op_ready = 1'($urandom % 2);
      if (mode == 1 && hs == 1 && op_valid && stall < 20) begin
        op_ready = 1'b0;
        stall++;
        if (op_code != 3'd2 || op_data != 4'(mb)) stall_ok = 0;
      end
      if (!busy) busy_ok = 0;
      h = op_valid & op_ready;
      tick();
      budget--;
      if (h) begin
        hs++;
        if (last >= 0 && cyc - last != 2) gap_ok = 0;
        last = cyc;
      end
    end
    op_ready = 1'b0;
    chk("issue_done", hs, 3);
    chk("issue_busy", busy_ok, 1);
    if (mode == 0) chk("issue_gap", gap_ok, 1);
    if (mode == 1) begin
      chk("stall_len", stall, 20);
      chk("stall_hold", stall_ok, 1);
    end
  endtask

  task automatic respond(int delay, bit force_neg);
    int r, mag;
    bit neg;
    r = (mop == 1) ? ma + mb : ma - mb;
    neg = (r < 0) || force_neg;
    mag = (r < 0) ? -r : r;
    repeat (delay) tick();
    res_valid = 1'b1;
    res_data = 8'(mag);
    res_neg = neg;
    model_end(1, mag, neg);
    tick();
    res_valid = 1'b0;
    res_neg = 1'b0;
    res_data = 8'($urandom);
    chk("resp_busy", busy, 0);
    chk("resp_err", disp_err, (ph == 6));
  endtask

  // monitors
  bit mon_en = 0;
  logic [15:0] seen = 16'hFFFF;
  bit p_stall = 0, p_hs = 0;
  logic [6:0] p_cmd = 7'd0;

  always @(negedge clk) begin
    if (mon_en && disp_value !== seen) begin
      if (dq.size() == 0)
        chk("disp_unexpected", disp_value, seen);
      else
        chk("disp", disp_value, dq.pop_front());
      seen = disp_value;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (p_stall) begin
        chk("hold_valid", op_valid, 1);
        chk("hold_cmd", {op_code, op_data}, p_cmd);
      end
      if (p_hs) chk("idle_gap", op_valid, 0);
      if (op_valid && op_ready) begin
        if (cq.size() == 0)
          chk("cmd_unexpected", {op_code, op_data}, 7'h7F);
        else
          chk("cmd", {op_code, op_data}, cq.pop_front());
      end
      p_stall = op_valid & ~op_ready;
      p_hs = op_valid & op_ready;
      p_cmd = {op_code, op_data};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, sel;
    repeat (3) tick();
    chk("rst_disp", disp_value, 16'hFFFF);
    chk("rst_valid", op_valid, 0);
    chk("rst_code", op_code, 0);
    chk("rst_data", op_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", disp_err, 0);
    reset_n = 1'b1;
    tick();
    mon_en = 1;

    // 3 + 4 = 7
    press(3); press(10); press(4);
    key_valid = 1'b1;
    key_value = 4'hE;
    model_key(14);
    tick();
    chk("entry_busy", busy, 1);
    chk("entry_valid", op_valid, 0);
    tick();
    chk("first_valid", op_valid, 1);
    chk("first_code", op_code, 1);
    chk("first_data", op_data, 3);
    key_valid = 1'b0;
    tick();
    do_issue(0);
    respond(5, 0);
    repeat (2) tick();
    chk("show_07", disp_value, 16'hFF07);

    // operator key in S_SHOW
    press(10);
    repeat (3) tick();
`ifdef CALC_CHAIN_EN
    chk("chain_small", disp_value, 16'h7AFF);
`else
    chk("show_op_ignored", disp_value, 16'hFF07);
`endif
    press(12);

    // 2 - 5 -> negative -> error
    press(2); press(11); press(5); press(14);
    do_issue(0);
    respond(3, 0);
    repeat (2) tick();
    chk("err_disp", disp_value, 16'hEEEE);
    chk("err_flag", disp_err, 1);
    press(7); press(10);
    chk("err_stays", disp_err, 1);
    press(12);
    repeat (2) tick();
    chk("clear_disp", disp_value, 16'hFFFF);

    // LOAD_B stall
    press(1); press(10); press(2); press(14);
    do_issue(1);
    respond(2, 0);

    // timeout
    press(12);
    press(4); press(11); press(1); press(14);
    do_issue(0);
    repeat (TO - 1) tick();
    chk("tmo_wait", busy, 1);
    model_end(0, 0, 0);
    tick();
    chk("tmo_busy", busy, 0);
    chk("tmo_err", disp_err, 1);

    // result on the timeout cycle wins
    press(12);
    press(8); press(10); press(8); press(14);
    do_issue(0);
    repeat (TO - 1) tick();
    res_valid = 1'b1;
    res_data = 8'd16;
    res_neg = 1'b0;
    model_end(1, 16, 0);
    tick();
    res_valid = 1'b0;
    chk("tmo_res_err", disp_err, 0);
    chk("tmo_res_busy", busy, 0);
    repeat (2) tick();
    chk("tmo_res_disp", disp_value, 16'hFF10);

    // long hold, then abort during wait
    press(12);
    press(6, 500);
    chk("hold_disp", disp_value, 16'h6FFF);
    press(10); press(2); press(14);
    do_issue(0);
    press(12, 2);
    respond(4, 1);
    repeat (2) tick();
    chk("abort_disp", disp_value, 16'hFFFF);
    chk("abort_err", disp_err, 0);

`ifdef CALC_CHAIN_EN
    press(9); press(10); press(9); press(14);
    do_issue(0);
    respond(3, 0);
    repeat (2) tick();
    chk("chain_18", disp_value, 16'hFF12);
    press(10);
    repeat (2) tick();
    chk("chain_big_err", disp_err, 1);
    press(12);
    press(5); press(10); press(3); press(14);
    do_issue(0);
    respond(3, 0);
    press(10);
    press(1);
    repeat (2) tick();
    chk("chain_entry", disp_value, 16'h8A1F);
    press(14);
    do_issue(0);
    respond(2, 0);
    press(12);
`endif

    // random traffic
    repeat (250) begin
      if (ph == 4) begin
        do_issue(2);
        sel = $urandom % 10;
        if (sel < 2) press(12, 1 + $urandom % 3);
        else if (sel < 4) begin
          k = $urandom % 16;
          if (k == 12) k = 0;
          press(k, 1 + $urandom % 3);
        end
        if ($urandom % 20 == 0) begin
          model_end(0, 0, 0);
          repeat (TO + 4) tick();
          chk("rnd_tmo_busy", busy, 0);
        end else respond($urandom % 15, 0);
      end else if ($urandom % 8 == 0) begin
        res_valid = 1'b1;
        res_data = 8'($urandom);
        res_neg = 1'($urandom);
        tick();
        res_valid = 1'b0;
        res_neg = 1'b0;
      end else begin
        sel = $urandom % 20;
        if (sel < 10) k = $urandom % 10;
        else if (sel < 13) k = 10;
        else if (sel < 15) k = 11;
        else if (sel < 18) k = 14;
        else if (sel == 18) k = 12;
        else k = ($urandom % 2) ? 13 : 15;
        press(k, 1 + $urandom % 3);
      end
    end

    repeat (5) tick();
    chk("disp_q_empty", dq.size(), 0);
    chk("cmd_q_empty", cq.size(), 0);
    chk("final_err", disp_err, (ph == 6));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
